// File: rtl/seq_detector_param_if.sv
// Bundle for the programmable serial pattern detector: configuration, qualified
// serial input and match/status outputs.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               in_valid;
  logic               in;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;
  logic               cfg_err;

  modport master (
    output cfg_load, pattern, pat_len, overlap, in_valid, in,
    input  out, match_cnt, armed, cfg_err
  );

  modport slave (
    input  cfg_load, pattern, pat_len, overlap, in_valid, in,
    output out, match_cnt, armed, cfg_err
  );
endinterface

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlap control,
// saturating match counter and illegal-length flag.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detector_param_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               legal_len;
  logic               match;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    out_d   = 1'b0;

    legal_len = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(MAX_LEN));
    hist_new  = {hist_q[MAX_LEN-2:0], bus.in};
    fill_inc  = {1'b0, fill_q} + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    // Only the low len bits take part; stale history above them is ignored.
    match = (fill_inc >= {1'b0, len_q}) && (((hist_new ^ pat_q) & len_mask) == '0);

    if (bus.cfg_load) begin
      pat_d   = bus.pattern;
      len_d   = bus.pat_len;
      ovl_d   = bus.overlap;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
      state_d = legal_len ? RUN : ERR;
      err_d   = !legal_len;
    end else if (state_q == RUN && bus.in_valid) begin
      hist_d = hist_new;
      fill_d = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
      if (match) begin
        out_d = 1'b1;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (!ovl_q) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all update together.
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.match_cnt = cnt_q;
  assign bus.armed     = (state_q == RUN);
  assign bus.cfg_err   = err_q;
endmodule
